// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
// Module  : motor_pkg
// Brief   : Shared state/direction encodings and sizing helper for motor_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
package motor_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] MOVE_UP = 3'd2;
  localparam logic [2:0] MOVE_DN = 3'd3;
  localparam logic [2:0] FAULT   = 3'd4;

  localparam logic UP = 1'b0;
  localparam logic DN = 1'b1;

  typedef struct packed {
    logic motor_up;
    logic motor_dn;
    logic busy;
    logic done;
    logic fault;
  } outs_t;

  // Wide enough to hold either load value; the timer never counts past it.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/motor_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : motor_ctrl_if
// Brief   : Command, limit-switch and drive bundle of motor_ctrl.
//           pos exists only when MOTOR_CTRL_POS_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
interface motor_ctrl_if
`ifdef MOTOR_CTRL_POS_EN
  #(parameter int POS_W = 16)
`endif
  ();
  logic activate;
  logic clr_fault;
  logic dn_limit;
  logic up_limit;
  logic motor_up;
  logic motor_dn;
  logic busy;
  logic done;
  logic fault;
`ifdef MOTOR_CTRL_POS_EN
  logic signed [POS_W-1:0] pos;
`endif

  modport master (
    output activate, clr_fault, dn_limit, up_limit,
    input  motor_up, motor_dn, busy, done, fault
`ifdef MOTOR_CTRL_POS_EN
    , input pos
`endif
  );

  modport slave (
    input  activate, clr_fault, dn_limit, up_limit,
    output motor_up, motor_dn, busy, done, fault
`ifdef MOTOR_CTRL_POS_EN
    , output pos
`endif
  );
endinterface
`default_nettype wire

// File: rtl/motor_timer.sv
`default_nettype none
// ============================================================================
// Module  : motor_timer
// Brief   : Loadable down-counter; expired_o is high while the count is zero.
// Revision: 1.0 - initial release
// ============================================================================
module motor_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/motor_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : motor_ctrl
// Brief   : Up/down motor controller with dead-time, travel timeout and fault
//           latch. Optional position counter: define MOTOR_CTRL_POS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module motor_ctrl
  import motor_pkg::*;
#(
  parameter int TIMEOUT_CYC  = 1000,
  parameter int DEADTIME_CYC = 16
`ifdef MOTOR_CTRL_POS_EN
  ,
  parameter int POS_W        = 16
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  motor_ctrl_if.slave bus
);

  localparam int               CNT_W     = cnt_width(TIMEOUT_CYC, DEADTIME_CYC);
  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEADTIME_CYC - 1);
  localparam logic [CNT_W-1:0] TIME_LOAD = CNT_W'(TIMEOUT_CYC - 1);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic             dir_q;
  logic             dir_d;
  logic             last_dir_q;
  logic             last_dir_d;
  logic             act_q;
  logic             act_rise;
  logic             both_lim;
  logic             done_d;
  outs_t            outs_q;
  outs_t            outs_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_exp;

  assign act_rise = bus.activate & ~act_q;
  assign both_lim = bus.up_limit & bus.dn_limit;

  // Priority per cycle: both limits, target limit, timeout, then activate edge.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    last_dir_d = last_dir_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (both_lim) begin
          state_d = FAULT;
        end else if (act_rise) begin
          state_d = START;
          dir_d   = bus.up_limit ? DN : (bus.dn_limit ? UP : ~last_dir_q);
        end
      end
      START: begin
        if (both_lim) begin
          state_d = FAULT;
        end else if (act_rise) begin
          state_d = IDLE;
        end else if (tmr_exp) begin
          state_d = (dir_q == UP) ? MOVE_UP : MOVE_DN;
        end
      end
      MOVE_UP, MOVE_DN: begin
        if (both_lim) begin
          state_d = FAULT;
        end else if ((state_q == MOVE_UP) ? bus.up_limit : bus.dn_limit) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          last_dir_d = dir_q;
        end else if (tmr_exp) begin
          state_d = FAULT;
        end else if (act_rise) begin
          state_d    = IDLE;
          last_dir_d = dir_q;
        end
      end
      FAULT: begin
        if (bus.clr_fault) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Timer reloads on entry to START (dead-time) or a MOVE state (timeout).
  always_comb begin
    tmr_load = (state_d != state_q) &&
               ((state_d == START) || (state_d == MOVE_UP) || (state_d == MOVE_DN));
    tmr_val  = (state_d == START) ? DEAD_LOAD : TIME_LOAD;
  end

  motor_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_exp)
  );

  always_comb begin
    outs_d          = '0;
    outs_d.motor_up = (state_d == MOVE_UP);
    outs_d.motor_dn = (state_d == MOVE_DN);
    outs_d.busy     = (state_d == START) || (state_d == MOVE_UP) || (state_d == MOVE_DN);
    outs_d.done     = done_d;
    outs_d.fault    = (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dir_q      <= DN;
      last_dir_q <= DN;
      act_q      <= 1'b0;
      outs_q     <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      last_dir_q <= last_dir_d;
      act_q      <= bus.activate;
      outs_q     <= outs_d;
    end
  end

  assign bus.motor_up = outs_q.motor_up;
  assign bus.motor_dn = outs_q.motor_dn;
  assign bus.busy     = outs_q.busy;
  assign bus.done     = outs_q.done;
  assign bus.fault    = outs_q.fault;

`ifdef MOTOR_CTRL_POS_EN
  localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

  logic signed [POS_W-1:0] pos_q;
  logic signed [POS_W-1:0] pos_d;

  // Reaching the lower limit on a down move re-homes the position to zero.
  always_comb begin
    pos_d = pos_q;
    if ((state_q == MOVE_DN) && bus.dn_limit && !both_lim) begin
      pos_d = '0;
    end else if ((state_q == MOVE_UP) && (pos_q != POS_MAX)) begin
      pos_d = pos_q + POS_W'(1);
    end else if ((state_q == MOVE_DN) && (pos_q != POS_MIN)) begin
      pos_d = pos_q - POS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign bus.pos = pos_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_motor_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_motor_ctrl
// Brief   : Directed scoreboard bench for motor_ctrl (TIMEOUT 20, DEADTIME 4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_motor_ctrl;

  // Output vector order: {motor_up, motor_dn, busy, done, fault}
  localparam logic [4:0] O_IDLE  = 5'b00000;
  localparam logic [4:0] O_START = 5'b00100;
  localparam logic [4:0] O_UP    = 5'b10100;
  localparam logic [4:0] O_DN    = 5'b01100;
  localparam logic [4:0] O_DONE  = 5'b00010;
  localparam logic [4:0] O_FAULT = 5'b00001;

  typedef struct {
    int         cyc;
    logic [4:0] val;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [4:0] mon_out;
  logic [4:0] mon_prev = 5'b11111;
  logic       end_req  = 1'b0;
  logic       end_done = 1'b0;

`ifdef MOTOR_CTRL_POS_EN
  typedef struct {
    int         cyc;
    logic [3:0] val;
  } pexp_t;
  pexp_t pos_q[$];
  pexp_t pos_e;

  motor_ctrl_if #(.POS_W(4)) bus ();

  motor_ctrl #(
    .TIMEOUT_CYC  (20),
    .DEADTIME_CYC (4),
    .POS_W        (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
`else
  motor_ctrl_if bus ();

  motor_ctrl #(
    .TIMEOUT_CYC  (20),
    .DEADTIME_CYC (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [4:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endtask

`ifdef MOTOR_CTRL_POS_EN
  task automatic push_pos(input int c, input logic [3:0] v);
    pexp_t e;
    e.cyc = c;
    e.val = v;
    pos_q.push_back(e);
  endtask
`endif

  task automatic next(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) next(1);
  endtask

  // Monitor: every change of the output vector consumes one expected entry.
  always @(negedge clk) begin
    mon_out = {bus.motor_up, bus.motor_dn, bus.busy, bus.done, bus.fault};
    if (mon_out !== mon_prev) begin
      mon_prev = mon_out;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change: got %b at cycle %0d, required no change", mon_out, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if ((mon_out !== mon_e.val) || ((mon_e.cyc >= 0) && (mon_e.cyc != cyc))) begin
          n_fail++;
          $display("FAIL outputs: got %b at cycle %0d, required %b at cycle %0d",
                   mon_out, cyc, mon_e.val, mon_e.cyc);
        end
      end
    end
`ifdef MOTOR_CTRL_POS_EN
    if ((pos_q.size() != 0) && (pos_q[0].cyc == cyc)) begin
      pos_e = pos_q.pop_front();
      n_checks++;
      if (bus.pos !== pos_e.val) begin
        n_fail++;
        $display("FAIL pos: got %0d at cycle %0d, required %0d", bus.pos, cyc, pos_e.val);
      end
    end
`endif
    if (end_req && !end_done) begin
      end_done = 1'b1;
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL missing_events: got %0d pending, required 0 (next %b at cycle %0d)",
                 exp_q.size(), exp_q[0].val, exp_q[0].cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.activate  = 1'b0;
    bus.clr_fault = 1'b0;
    bus.dn_limit  = 1'b0;
    bus.up_limit  = 1'b0;
    push(-1, O_IDLE);
    next(3);
    rst_n = 1'b1;
    next(2);

    // Move up to the upper limit
    t = cyc; bus.activate = 1'b1;
    push(t + 1, O_START); push(t + 5, O_UP);
    goto(t + 1);  bus.activate = 1'b0;
    goto(t + 10); bus.up_limit = 1'b1;
    push(t + 11, O_DONE); push(t + 12, O_IDLE);
    goto(t + 11); bus.up_limit = 1'b0;
    goto(t + 14);

    // Direction memory: next move is down, ends on lower limit
    t = cyc; bus.activate = 1'b1;
    push(t + 1, O_START); push(t + 5, O_DN);
    goto(t + 1); bus.activate = 1'b0;
    goto(t + 8); bus.dn_limit = 1'b1;
    push(t + 9, O_DONE); push(t + 10, O_IDLE);
    goto(t + 12);

    // Up again, then aborted mid-move by a second rise
    t = cyc; bus.activate = 1'b1;
    push(t + 1, O_START); push(t + 5, O_UP);
    goto(t + 1); bus.activate = 1'b0;
    goto(t + 6); bus.dn_limit = 1'b0;
    goto(t + 7); bus.activate = 1'b1;
    push(t + 8, O_IDLE);
    goto(t + 8); bus.activate = 1'b0;
    goto(t + 10);

    // Down move, both limits -> fault; activate ignored; clear
    t = cyc; bus.activate = 1'b1;
    push(t + 1, O_START); push(t + 5, O_DN);
    goto(t + 1); bus.activate = 1'b0;
    goto(t + 6); bus.up_limit = 1'b1; bus.dn_limit = 1'b1;
    push(t + 7, O_FAULT);
    goto(t + 8); bus.up_limit = 1'b0; bus.dn_limit = 1'b0; bus.activate = 1'b1;
    goto(t + 9); bus.activate = 1'b0;
    goto(t + 10); bus.clr_fault = 1'b1;
    push(t + 11, O_IDLE);
    goto(t + 11); bus.clr_fault = 1'b0;
    goto(t + 13);

    // Travel timeout: 20 MOVE cycles with no limit
    t = cyc; bus.activate = 1'b1;
    push(t + 1, O_START); push(t + 5, O_DN); push(t + 25, O_FAULT);
    goto(t + 1);  bus.activate = 1'b0;
    goto(t + 27); bus.activate = 1'b1;
    goto(t + 28); bus.activate = 1'b0;
    goto(t + 30); bus.clr_fault = 1'b1;
    push(t + 31, O_IDLE);
    goto(t + 31); bus.clr_fault = 1'b0;
    goto(t + 33);

    // Abort during dead-time
    t = cyc; bus.activate = 1'b1;
    push(t + 1, O_START);
    goto(t + 1); bus.activate = 1'b0;
    goto(t + 2); bus.activate = 1'b1;
    push(t + 3, O_IDLE);
    goto(t + 3); bus.activate = 1'b0;
    goto(t + 6);

    // Both limits while idle
    t = cyc; bus.up_limit = 1'b1; bus.dn_limit = 1'b1;
    push(t + 1, O_FAULT);
    goto(t + 1); bus.up_limit = 1'b0; bus.dn_limit = 1'b0;
    goto(t + 3); bus.clr_fault = 1'b1;
    push(t + 4, O_IDLE);
    goto(t + 4); bus.clr_fault = 1'b0;
    goto(t + 6);

    // Asynchronous reset mid MOVE_UP
    t = cyc; bus.dn_limit = 1'b1; bus.activate = 1'b1;
    push(t + 1, O_START); push(t + 5, O_UP);
    goto(t + 1); bus.activate = 1'b0; bus.dn_limit = 1'b0;
    goto(t + 7); push(t + 7, O_IDLE); rst_n = 1'b0;
    goto(t + 9); rst_n = 1'b1;
    goto(t + 11);

    // After reset the first move is up again
    t = cyc; bus.activate = 1'b1;
    push(t + 1, O_START); push(t + 5, O_UP);
    goto(t + 1); bus.activate = 1'b0;
    goto(t + 6); bus.up_limit = 1'b1;
    push(t + 7, O_DONE); push(t + 8, O_IDLE);
    goto(t + 7); bus.up_limit = 1'b0;
    goto(t + 10);

`ifdef MOTOR_CTRL_POS_EN
    push_pos(cyc, 4'd2);
    goto(cyc + 1);
    // Ten up cycles from 2 saturate at 7
    t = cyc; bus.dn_limit = 1'b1; bus.activate = 1'b1;
    push(t + 1, O_START); push(t + 5, O_UP);
    goto(t + 1);  bus.activate = 1'b0; bus.dn_limit = 1'b0;
    goto(t + 14); bus.up_limit = 1'b1;
    push(t + 15, O_DONE); push(t + 16, O_IDLE); push_pos(t + 16, 4'd7);
    goto(t + 15); bus.up_limit = 1'b0;
    goto(t + 17);
    // Homing down run
    t = cyc; bus.activate = 1'b1;
    push(t + 1, O_START); push(t + 5, O_DN);
    goto(t + 1); bus.activate = 1'b0;
    goto(t + 7); bus.dn_limit = 1'b1; push_pos(t + 7, 4'd5);
    push(t + 8, O_DONE); push(t + 9, O_IDLE); push_pos(t + 9, 4'd0);
    goto(t + 9); bus.dn_limit = 1'b0;
    goto(t + 11);
`endif

    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_done; i++) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/motor_ctrl.md
Name: motor_ctrl

Overview:
- Parametrised single-axis up/down motor controller, the successor to the fixed three-state motor FSM.
- Adds rising-edge activate with abort, direction memory, a programmable dead-time before any drive, a travel timeout with fault latch, and sensor-error detection.
- Sits between the operator/host command logic and the motor driver enables; limit switches arrive already synchronised.

Parameters:
- TIMEOUT_CYC, 1000, max cycles in a MOVE state before fault; must be >= 2.
- DEADTIME_CYC, 16, cycles spent in START with both drives low before drive asserts; must be >= 1.
- POS_W, 16, width of the position counter (optional feature only).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- activate  in  1  command level; only its rising edge acts
- clr_fault  in  1  single-cycle pulse; clears FAULT
- dn_limit  in  1  lower limit switch, active-high
- up_limit  in  1  upper limit switch, active-high
- motor_up  out  1  drive up, registered
- motor_dn  out  1  drive down, registered
- busy  out  1  high in START, MOVE_UP, MOVE_DN
- done  out  1  one-cycle pulse when a move ends at its limit
- fault  out  1  high in FAULT
- pos  out  POS_W  signed position count (MOTOR_CTRL_POS_EN only)

Behaviour:
- Reset values: all outputs 0, state IDLE, last_dir = DN (so the first move is UP), act_q = 0, counter 0.
- act_rise = activate & ~act_q, where act_q is activate registered each cycle.
- Outputs are decoded from next-state, so all outputs are registered with no added latency.
- IDLE:
  - act_rise -> START.
  - Chosen direction: DN if up_limit; else UP if dn_limit; else the opposite of last_dir.
  - Chosen direction is latched into dir.
- START:
  - Both drives 0; counter counts DEADTIME_CYC cycles, then -> MOVE_UP or MOVE_DN per dir.
  - act_rise in START -> IDLE (abort); no done pulse.
  - Rise at cycle T: busy = 1 at T+1, drive = 1 at T+1+DEADTIME_CYC.
- MOVE_UP (motor_up = 1) and MOVE_DN (motor_dn = 1):
  - Counter restarts on entry.
  - Target limit high -> IDLE, drive 0 next cycle, done pulse 1 cycle, last_dir <= dir.
  - act_rise -> IDLE, drive 0, no done, last_dir <= dir.
  - Counter reaches TIMEOUT_CYC-1 with no limit -> FAULT.
- FAULT:
  - Drives 0, fault = 1.
  - Only clr_fault leaves it (-> IDLE); activate is ignored.
- Both limits high, any state except FAULT -> FAULT next cycle.
- Priority within a cycle: both-limits > target limit > timeout > act_rise.
- Both drives are never high together; there is no direct MOVE->MOVE transition, so every reversal passes through IDLE and START.
- Counter width: $clog2(max(TIMEOUT_CYC, DEADTIME_CYC)+1); no wrap is possible.
- Async reset mid-move drops both drives immediately.

Optional Feature:
- Macro MOTOR_CTRL_POS_EN.
- With the macro defined:
  - pos port exists; +1 per MOVE_UP cycle, -1 per MOVE_DN cycle.
  - Saturates at signed max/min.
  - Cleared to 0 when MOVE_DN ends on dn_limit (homing); reset value 0.
- Without the macro: no pos port and no counter logic; all other behaviour identical.

Decomposition:
- Shared package motor_pkg holds:
  - state encoding constants: IDLE, START, MOVE_UP, MOVE_DN, FAULT;
  - direction constants UP/DN.
- One natural sub-module: motor_timer.
  - Loadable down-counter with an expiry flag.
  - Instantiated once and reused for dead-time and timeout.

Test Plan (TIMEOUT_CYC=20, DEADTIME_CYC=4):
- Reset, no limits, activate rise at T -> busy at T+1, motor_up at T+5; up_limit at T+10 -> motor_up = 0 and done pulse at T+11, then IDLE.
- Second activate rise after that move -> motor_dn after 4 dead-time cycles; dn_limit ends the move with done; third rise moves UP again.
- Activate rise while MOVE_UP -> motor_up = 0 next cycle, no done; next rise moves DN via START.
- Move with no limit -> after 20 MOVE cycles fault = 1 and drives 0; activate ignored; clr_fault -> IDLE, fault = 0.
- up_limit and dn_limit both asserted during MOVE_DN -> FAULT next cycle; same with both asserted in IDLE.
- rst_n low mid-MOVE_UP -> motor_up = 0 asynchronously. With MOTOR_CTRL_POS_EN, POS_W=4: 10 UP cycles -> pos = 7 (saturated); homing DN run -> pos = 0.
